// File: rtl/line_sequencer_if.sv
// line_sequencer_if: sample-side inputs and output-stage controls of the line sequencer.
interface line_sequencer_if #(parameter int W = 6);
  logic         ce;
  logic         sync_in;
  logic [W-1:0] sample;
  logic [1:0]   mode;
  logic [W-1:0] blacklevel;
  logic [W-1:0] ceiling;
  logic         locked;
  logic         field_sync;
  logic [8:0]   line_num;
  modport master (output ce, sync_in, sample,
                  input  mode, blacklevel, ceiling, locked, field_sync, line_num);
  modport slave  (input  ce, sync_in, sample,
                  output mode, blacklevel, ceiling, locked, field_sync, line_num);
endinterface

// File: rtl/line_sequencer.sv
// line_sequencer: per-line sync / back porch / black-level measure / active timing controller.
// Define VBI_BLANK_EN to blank ACTIVE for the first VBI_LINES lines after each field start.
module line_sequencer #(
  parameter int W             = 6,
  parameter int AVG_LOG2      = 5,
  parameter int PORCH_DELAY   = 24,
  parameter int SYNC_MIN      = 40,
  parameter int VSYNC_MIN     = 240,
  parameter int SYNC_MAX      = 1536,
  parameter int LINE_MIN      = 720,
  parameter int LINE_MAX      = 1600,
  parameter int LOCK_LINES    = 8,
  parameter int BLACK_DEFAULT = 8,
  parameter int SPAN          = 24
`ifdef VBI_BLANK_EN
  , parameter int VBI_LINES   = 16
`endif
) (
  input logic clk,
  input logic reset_n,
  line_sequencer_if.slave bus
);
  localparam int AW = W + AVG_LOG2;
  localparam int CEIL_INT = (BLACK_DEFAULT + SPAN > 2**W - 1) ? 2**W - 1 : BLACK_DEFAULT + SPAN;
  localparam logic [10:0]  CNT_MAX     = 11'd2047;
  localparam logic [10:0]  SYNC_MIN_C  = 11'(SYNC_MIN);
  localparam logic [10:0]  VSYNC_MIN_C = 11'(VSYNC_MIN);
  localparam logic [10:0]  SYNC_MAX_C  = 11'(SYNC_MAX);
  localparam logic [10:0]  LINE_MIN_C  = 11'(LINE_MIN);
  localparam logic [10:0]  LINE_MAX_C  = 11'(LINE_MAX);
  localparam logic [10:0]  PORCH_END   = 11'(PORCH_DELAY - 1);
  localparam logic [10:0]  MEAS_END    = 11'(2**AVG_LOG2 - 1);
  localparam logic [3:0]   LOCK_C      = 4'(LOCK_LINES);
  localparam logic [W-1:0] BLACK_RST   = W'(BLACK_DEFAULT);
  localparam logic [W-1:0] CEIL_RST    = W'(CEIL_INT);
  localparam logic [W:0]   SPAN_C      = (W+1)'(SPAN);

  typedef enum logic [2:0] {SEARCH, SYNC, BACKPORCH, MEASURE, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic          sync_q, sync_p_q, rise, fall, good, bad, lost;
  logic [10:0]   cyc_q, cyc_d, lcnt_q, lcnt_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic          broad_q, broad_d, locked_q, locked_d, field_sync_q, field_sync_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [W-1:0]  avg, blacklevel_q, blacklevel_d, ceiling_q, ceiling_d;
  logic [W:0]    ceil_sum;
  logic [8:0]    line_num_q, line_num_d;
  logic [1:0]    mode_q, mode_d, active_mode;

  always_comb begin
    rise         = sync_q & ~sync_p_q;
    fall         = ~sync_q & sync_p_q;
    sum          = acc_q + AW'(bus.sample);
    avg          = sum[AW-1:AVG_LOG2];
    ceil_sum     = {1'b0, avg} + SPAN_C;
    state_d      = state_q;
    broad_d      = broad_q;
    line_num_d   = line_num_q;
    blacklevel_d = blacklevel_q;
    ceiling_d    = ceiling_q;
    field_sync_d = 1'b0;
    acc_d        = '0;
    good         = 1'b0;
    bad          = 1'b0;
    lost         = 1'b0;
    case (state_q)
      SEARCH: if (rise) state_d = SYNC;
      SYNC: begin
        if (fall) begin
          if (cyc_q < SYNC_MIN_C) begin
            lost    = 1'b1;
            state_d = SEARCH;
          end else begin
            state_d      = BACKPORCH;
            broad_d      = cyc_q >= VSYNC_MIN_C;
            field_sync_d = broad_d & ~broad_q;
            line_num_d   = broad_d ? (broad_q ? line_num_q : '0)
                         : (line_num_q == 9'd511) ? line_num_q : line_num_q + 9'd1;
          end
        end else if (cyc_q == SYNC_MAX_C) begin
          lost    = 1'b1;
          state_d = SEARCH;
        end
      end
      BACKPORCH: begin
        if (rise) begin
          bad     = 1'b1;
          state_d = SYNC;
        end else if (cyc_q == PORCH_END) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          bad     = 1'b1;
          state_d = SYNC;
        end else if (cyc_q == MEAS_END) begin
          // a broad (vertical) line still measures, but its result is dropped
          if (!broad_q) begin
            blacklevel_d = avg;
            ceiling_d    = ceil_sum[W] ? '1 : ceil_sum[W-1:0];
          end
          state_d = ACTIVE;
        end else acc_d = sum;
      end
      ACTIVE: begin
        if (rise) begin
          good    = (lcnt_q >= LINE_MIN_C) && (lcnt_q <= LINE_MAX_C);
          bad     = ~good;
          state_d = SYNC;
        end else if (lcnt_q == LINE_MAX_C) begin
          lost    = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
    gcnt_d   = (bad | lost) ? '0 : (good && gcnt_q != LOCK_C) ? gcnt_q + 4'd1 : gcnt_q;
    locked_d = gcnt_d == LOCK_C;
    cyc_d    = (state_d != state_q) ? '0 : (cyc_q == CNT_MAX) ? cyc_q : cyc_q + 11'd1;
    lcnt_d   = rise ? '0 : (lcnt_q == CNT_MAX) ? lcnt_q : lcnt_q + 11'd1;
`ifdef VBI_BLANK_EN
    active_mode = (line_num_d < 9'(VBI_LINES)) ? 2'd1 : 2'd2;
`else
    active_mode = 2'd2;
`endif
    mode_d = (state_d == SYNC) ? 2'd0 : (state_d == ACTIVE) ? active_mode : 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      sync_q       <= 1'b0;
      sync_p_q     <= 1'b0;
      cyc_q        <= '0;
      lcnt_q       <= '0;
      gcnt_q       <= '0;
      broad_q      <= 1'b0;
      acc_q        <= '0;
      blacklevel_q <= BLACK_RST;
      ceiling_q    <= CEIL_RST;
      locked_q     <= 1'b0;
      field_sync_q <= 1'b0;
      line_num_q   <= '0;
      mode_q       <= 2'd1;
    end else if (bus.ce) begin
      state_q      <= state_d;
      sync_q       <= bus.sync_in;
      sync_p_q     <= sync_q;
      cyc_q        <= cyc_d;
      lcnt_q       <= lcnt_d;
      gcnt_q       <= gcnt_d;
      broad_q      <= broad_d;
      acc_q        <= acc_d;
      blacklevel_q <= blacklevel_d;
      ceiling_q    <= ceiling_d;
      locked_q     <= locked_d;
      field_sync_q <= field_sync_d;
      line_num_q   <= line_num_d;
      mode_q       <= mode_d;
    end else field_sync_q <= 1'b0;
  end

  assign bus.mode       = mode_q;
  assign bus.blacklevel = blacklevel_q;
  assign bus.ceiling    = ceiling_q;
  assign bus.locked     = locked_q;
  assign bus.field_sync = field_sync_q;
  assign bus.line_num   = line_num_q;
endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer: directed line/pulse patterns checked every cycle against a timeline model,
// plus literal expectations at key points of the sequence.
module tb_line_sequencer;
  localparam int PH_SEARCH = 0, PH_SYNC = 1, PH_PORCH = 2, PH_MEAS = 3, PH_ACTIVE = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  line_sequencer_if #(.W(6)) bus();
  line_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, fs_cnt = 0;
  bit gappy = 1'b0;
  logic [1:0] mq[$];
  logic [1:0] last_mode = 2'bxx;

  int m_phase, n, entry, last_rise, gcnt, acc, m_bl, m_ceil, m_lnum;
  bit h1, h2, broad, m_fs, m_lock, m_ok = 1'b0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [1:0] exp_mode();
    if (m_phase == PH_SYNC) return 2'd0;
`ifdef VBI_BLANK_EN
    if (m_phase == PH_ACTIVE) return (m_lnum < 16) ? 2'd1 : 2'd2;
`else
    if (m_phase == PH_ACTIVE) return 2'd2;
`endif
    return 2'd1;
  endfunction

  // Timeline model: ticks count ce edges; sync edges are seen one tick after they are sampled.
  always @(posedge clk) begin : model
    int cyc, lc, nxt;
    bit rise, fall;
    if (!reset_n) begin
      m_phase = PH_SEARCH; n = 0; entry = 0; last_rise = 0; gcnt = 0; acc = 0;
      m_bl = 8; m_ceil = 32; m_lnum = 0; h1 = 0; h2 = 0; broad = 0;
      m_fs = 0; m_lock = 0; m_ok = 1;
    end else if (!bus.ce) m_fs = 0;
    else begin
      n++;
      rise = h1 && !h2;
      fall = !h1 && h2;
      cyc = imin(n - entry - 1, 2047);
      lc = imin(n - last_rise - 1, 2047);
      nxt = m_phase;
      m_fs = 0;
      case (m_phase)
        PH_SEARCH: if (rise) nxt = PH_SYNC;
        PH_SYNC: begin
          if (fall) begin
            if (cyc < 40) begin gcnt = 0; nxt = PH_SEARCH; end
            else begin
              if (cyc >= 240) begin
                if (!broad) begin m_fs = 1; m_lnum = 0; end
                broad = 1;
              end else begin
                broad = 0;
                m_lnum = imin(m_lnum + 1, 511);
              end
              nxt = PH_PORCH;
            end
          end else if (cyc == 1536) begin gcnt = 0; nxt = PH_SEARCH; end
        end
        PH_PORCH: begin
          if (rise) begin gcnt = 0; nxt = PH_SYNC; end
          else if (cyc == 23) nxt = PH_MEAS;
        end
        PH_MEAS: begin
          if (rise) begin gcnt = 0; nxt = PH_SYNC; end
          else begin
            acc += int'(bus.sample);
            if (cyc == 31) begin
              if (!broad) begin m_bl = acc / 32; m_ceil = imin(m_bl + 24, 63); end
              nxt = PH_ACTIVE;
            end
          end
        end
        PH_ACTIVE: begin
          if (rise) begin
            gcnt = (lc >= 720 && lc <= 1600) ? imin(gcnt + 1, 8) : 0;
            nxt = PH_SYNC;
          end else if (lc == 1600) begin gcnt = 0; nxt = PH_SEARCH; end
        end
        default: ;
      endcase
      if (rise) last_rise = n;
      if (nxt != m_phase) begin entry = n; acc = 0; end
      m_phase = nxt;
      m_lock = (gcnt == 8);
      h2 = h1;
      h1 = bus.sync_in;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      checks++;
      if (bus.mode !== exp_mode() || bus.blacklevel !== 6'(m_bl) || bus.ceiling !== 6'(m_ceil) ||
          bus.locked !== m_lock || bus.field_sync !== m_fs || bus.line_num !== 9'(m_lnum)) begin
        failures++;
        if (failures <= 20)
          $display("FAIL cycle_compare t=%0t got mode=%0d bl=%0d ceil=%0d lock=%0b fs=%0b line=%0d expected mode=%0d bl=%0d ceil=%0d lock=%0b fs=%0b line=%0d",
                   $time, bus.mode, bus.blacklevel, bus.ceiling, bus.locked, bus.field_sync, bus.line_num,
                   exp_mode(), m_bl, m_ceil, m_lock, m_fs, m_lnum);
      end
    end
    if (bus.mode !== last_mode) begin
      mq.push_back(bus.mode);
      last_mode = bus.mode;
    end
    if (bus.field_sync === 1'b1) fs_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic [5:0] v);
    if (gappy) begin
      @(negedge clk);
      bus.ce = 1'b0;
    end
    @(negedge clk);
    bus.ce = 1'b1;
    bus.sync_in = s;
    bus.sample = v;
  endtask

  task automatic send_line(input int w, input int t, input logic [5:0] v);
    for (int i = 0; i < t; i++) step(i < w, (i >= w + 10 && i < w + 70) ? v : 6'd33);
    #1;
  endtask

  initial begin
    int fs0;
    bus.ce = 1'b1;
    bus.sync_in = 1'b0;
    bus.sample = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_mode", 32'(bus.mode), 1);
    chk("rst_blacklevel", 32'(bus.blacklevel), 8);
    chk("rst_ceiling", 32'(bus.ceiling), 32);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_field_sync", 32'(bus.field_sync), 0);
    chk("rst_line_num", 32'(bus.line_num), 0);

    repeat (8) send_line(113, 1536, 6'd12);
    chk("unlocked_after_8_lines", 32'(bus.locked), 0);
    send_line(113, 1536, 6'd12);
    chk("locked_at_9th_rise", 32'(bus.locked), 1);
    mq.delete();
    send_line(113, 1536, 6'd12);
`ifdef VBI_BLANK_EN
    chk("mode_seq_len", 32'(mq.size()), 2);
    chk("mode_seq_0", 32'(mq[0]), 0);
    chk("mode_seq_1", 32'(mq[1]), 1);
`else
    chk("mode_seq_len", 32'(mq.size()), 3);
    chk("mode_seq_0", 32'(mq[0]), 0);
    chk("mode_seq_1", 32'(mq[1]), 1);
    chk("mode_seq_2", 32'(mq[2]), 2);
`endif
    chk("blacklevel_12", 32'(bus.blacklevel), 12);
    chk("ceiling_36", 32'(bus.ceiling), 36);
    chk("line_num_10", 32'(bus.line_num), 10);

    send_line(113, 1536, 6'd63);
    chk("blacklevel_63", 32'(bus.blacklevel), 63);
    chk("ceiling_saturated", 32'(bus.ceiling), 63);

    send_line(113, 700, 6'd12);
    send_line(20, 300, 6'd12);
    chk("glitch_unlocks", 32'(bus.locked), 0);
    chk("glitch_search_mode", 32'(bus.mode), 1);
    repeat (8) send_line(113, 1536, 6'd12);
    chk("relock_not_yet", 32'(bus.locked), 0);
    send_line(113, 1536, 6'd12);
    chk("relocked", 32'(bus.locked), 1);

    fs0 = fs_cnt;
    send_line(300, 1536, 6'd20);
    chk("broad_one_field_pulse", 32'(fs_cnt - fs0), 1);
    chk("broad_line_num_0", 32'(bus.line_num), 0);
    chk("broad_keeps_blacklevel", 32'(bus.blacklevel), 12);
`ifdef VBI_BLANK_EN
    chk("line0_active_mode", 32'(bus.mode), 1);
`else
    chk("line0_active_mode", 32'(bus.mode), 2);
`endif
    send_line(300, 1536, 6'd20);
    chk("second_broad_no_pulse", 32'(fs_cnt - fs0), 1);
    send_line(113, 1536, 6'd12);
    chk("line_num_1_after_field", 32'(bus.line_num), 1);

    send_line(113, 1601, 6'd12);
    send_line(113, 1536, 6'd12);
    chk("rise_beats_line_max", 32'(bus.locked), 1);

    send_line(113, 1700, 6'd12);
    chk("sync_lost_unlock", 32'(bus.locked), 0);
    chk("sync_lost_search", 32'(bus.mode), 1);

    send_line(113, 1536, 6'd12);
    send_line(1600, 1700, 6'd12);
    chk("sync_stuck_search", 32'(bus.mode), 1);
    chk("sync_stuck_unlock", 32'(bus.locked), 0);

    gappy = 1'b1;
    repeat (2) send_line(113, 1536, 6'd30);
    chk("gappy_blacklevel", 32'(bus.blacklevel), 30);
    fs0 = fs_cnt;
    send_line(300, 1536, 6'd30);
    chk("gappy_field_pulse", 32'(fs_cnt - fs0), 1);
    gappy = 1'b0;

    for (int i = 0; i < 140; i++) step(i < 113, 6'd12);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midmeasure_reset_bl", 32'(bus.blacklevel), 8);
    chk("midmeasure_reset_ceil", 32'(bus.ceiling), 32);
    chk("midmeasure_reset_mode", 32'(bus.mode), 1);
    send_line(113, 1536, 6'd12);
    chk("post_reset_blacklevel", 32'(bus.blacklevel), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
